// File: rtl/acc_sequencer.sv
// Instruction fetch/decode sequencer for the 8-bit processor: fetches over a req/ack port,
// decodes, and emits one execute pulse per instruction on the accumulator control lines.
//
// state   | meaning
// FETCH   | request opcode byte at pc, wait for ack
// DECODE  | one idle cycle, choose operand fetch / execute / halt
// OPERAND | request jump target byte at pc, wait for ack
// EXEC    | one-cycle control pulse, jump pc update
// HALT    | stopped until reset
module acc_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  input  logic              flag_c,
  output logic              jump,
  output logic              jumpC,
  output logic              sin,
  output logic              InA,
  output logic              twone,
  output logic [2:0]        alu_op,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        ir, ir_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [ADDR_W-1:0] tgt, tgt_nxt;
  logic [3:0]        opcode;

  assign opcode   = ir[7:4];
  assign pc       = pc_q;
  assign mem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc_q  <= '0;
      ir    <= '0;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir    <= ir_nxt;
      tgt   <= tgt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir;
    tgt_nxt   = tgt;
    mem_rd    = 1'b0;
    jump      = 1'b0;
    jumpC     = 1'b0;
    sin       = 1'b0;
    InA       = 1'b0;
    twone     = 1'b0;
    alu_op    = 3'd0;
    halted    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_nxt    = mem_data;
          pc_nxt    = pc_q + ADDR_W'(1);
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          4'h8, 4'h9: state_nxt = S_OPERAND;
          4'hF:       state_nxt = S_HALT;
          default:    state_nxt = S_EXEC;
        endcase
      end
      S_OPERAND: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          tgt_nxt   = ADDR_W'(mem_data);
          pc_nxt    = pc_q + ADDR_W'(1);
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4: begin
            twone  = 1'b1;
            alu_op = ir[2:0];
          end
          4'h5, 4'h6: begin
            sin    = 1'b1;
            alu_op = ir[2:0];
          end
          4'h7: begin
            twone  = 1'b1;
            InA    = 1'b1;
            alu_op = ir[2:0];
          end
          4'h8: begin
            jump   = 1'b1;
            pc_nxt = tgt;
          end
          4'h9: begin
            jumpC = 1'b1;
            if (flag_c) pc_nxt = tgt;
          end
          default: ;
        endcase
        state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase

    // Keep the port quiet for the whole reset cycle, so no handshake can start under reset.
    if (!rst_n) begin
      mem_rd = 1'b0;
      jump   = 1'b0;
      jumpC  = 1'b0;
      sin    = 1'b0;
      InA    = 1'b0;
      twone  = 1'b0;
      alu_op = 3'd0;
      halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed latency/boundary scenarios plus randomized
// programs checked against an instruction-level interpreter of the processor.
module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, mem_rd, mem_ack, flag_c;
  logic       jump, jumpC, sin, InA, twone, halted;
  logic [7:0] mem_addr, mem_data, pc;
  logic [2:0] alu_op;
  logic [4:0] ctl;
  logic [7:0] mem [256];
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];
  assign ctl      = {jump, jumpC, sin, InA, twone};

  acc_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .flag_c(flag_c), .jump(jump), .jumpC(jumpC), .sin(sin), .InA(InA),
    .twone(twone), .alu_op(alu_op), .pc(pc), .halted(halted)
  );

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem(input logic [7:0] fill);
    for (int i = 0; i < 256; i++) mem[i] = fill;
  endtask

  // Leaves the bench in the first cycle after release (cycle 1), sampled mid-cycle.
  task automatic do_reset;
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    flag_c  = 1'b0;
    next_cycle;
    next_cycle;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic observe(input bit rnd, output logic [4:0] c, output logic [2:0] op,
                         output logic rd, output logic h, output logic fc);
    if (rnd) begin
      mem_ack = 1'($urandom_range(0, 1));
      flag_c  = 1'($urandom_range(0, 1));
    end
    c  = ctl;
    op = alu_op;
    rd = mem_rd;
    h  = halted;
    fc = flag_c;
    next_cycle;
  endtask

  task automatic handshake(output bit ok, output logic [7:0] addr, output bit stable,
                           output bit quiet);
    ok     = 1'b0;
    stable = 1'b1;
    quiet  = 1'b1;
    addr   = mem_addr;
    for (int k = 0; k < 64 && !ok; k++) begin
      mem_ack = ($urandom_range(0, 3) != 0);
      if (mem_rd !== 1'b1 || mem_addr !== addr) stable = 1'b0;
      if (ctl !== 5'b0 || halted !== 1'b0) quiet = 1'b0;
      if (mem_ack && mem_rd === 1'b1) ok = 1'b1;
      next_cycle;
    end
  endtask

  task automatic test_reset;
    clear_mem(8'h00);
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    flag_c  = 1'b1;
    next_cycle;
    next_cycle;
    n_total++;
    if ({mem_rd, ctl, alu_op, halted} !== 10'b0)
      $display("FAIL reset_outputs: got %b want 0", {mem_rd, ctl, alu_op, halted});
    else n_pass++;
    n_total++;
    if ({pc, mem_addr} !== 16'h0000) $display("FAIL reset_pc: got pc=%h addr=%h want 00", pc, mem_addr);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'h00})
      $display("FAIL reset_release_fetch: got rd=%b addr=%h want rd=1 addr=00", mem_rd, mem_addr);
    else n_pass++;
  endtask

  task automatic test_sub_latency;
    clear_mem(8'h00);
    mem[0] = 8'h12;
    do_reset;
    mem_ack = 1'b1;
    n_total++;
    if ({mem_rd, mem_addr, ctl} !== {1'b1, 8'h00, 5'b0})
      $display("FAIL sub_c1: got rd=%b addr=%h ctl=%b want 1/00/0", mem_rd, mem_addr, ctl);
    else n_pass++;
    next_cycle;
    n_total++;
    if ({pc, mem_rd, ctl} !== {8'h01, 1'b0, 5'b0})
      $display("FAIL sub_c2: got pc=%h rd=%b ctl=%b want 01/0/0", pc, mem_rd, ctl);
    else n_pass++;
    next_cycle;
    n_total++;
    if ({ctl, alu_op} !== {5'b00001, 3'd2})
      $display("FAIL sub_c3: got ctl=%b op=%0d want 00001/2", ctl, alu_op);
    else n_pass++;
    next_cycle;
    n_total++;
    if ({ctl, alu_op, mem_rd, mem_addr} !== {5'b0, 3'd0, 1'b1, 8'h01})
      $display("FAIL sub_c4: got ctl=%b op=%0d rd=%b addr=%h want 0/0/1/01", ctl, alu_op, mem_rd, mem_addr);
    else n_pass++;
  endtask

  task automatic test_jmp;
    clear_mem(8'h00);
    mem[0] = 8'h80;
    mem[1] = 8'h40;
    do_reset;
    mem_ack = 1'b1;
    next_cycle;
    next_cycle;
    n_total++;
    if ({mem_rd, mem_addr, ctl} !== {1'b1, 8'h01, 5'b0})
      $display("FAIL jmp_operand: got rd=%b addr=%h ctl=%b want 1/01/0", mem_rd, mem_addr, ctl);
    else n_pass++;
    next_cycle;
    n_total++;
    if ({ctl, alu_op} !== {5'b10000, 3'd0})
      $display("FAIL jmp_exec: got ctl=%b op=%0d want 10000/0", ctl, alu_op);
    else n_pass++;
    next_cycle;
    n_total++;
    if ({ctl, mem_rd, mem_addr} !== {5'b0, 1'b1, 8'h40})
      $display("FAIL jmp_next_fetch: got ctl=%b rd=%b addr=%h want 0/1/40", ctl, mem_rd, mem_addr);
    else n_pass++;
  endtask

  task automatic test_jc(input logic fc, input logic [7:0] want);
    clear_mem(8'h00);
    mem[0] = 8'h90;
    mem[1] = 8'h20;
    do_reset;
    mem_ack = 1'b1;
    flag_c  = fc;
    next_cycle;
    next_cycle;
    next_cycle;
    n_total++;
    if ({ctl, alu_op} !== {5'b01000, 3'd0})
      $display("FAIL jc_exec_c%0d: got ctl=%b op=%0d want 01000/0", fc, ctl, alu_op);
    else n_pass++;
    next_cycle;
    n_total++;
    if ({ctl, mem_rd, mem_addr} !== {5'b0, 1'b1, want})
      $display("FAIL jc_next_fetch_c%0d: got ctl=%b rd=%b addr=%h want 0/1/%h", fc, ctl, mem_rd, mem_addr, want);
    else n_pass++;
  endtask

  task automatic test_in;
    clear_mem(8'h00);
    mem[0] = 8'h73;
    do_reset;
    mem_ack = 1'b1;
    next_cycle;
    next_cycle;
    n_total++;
    if ({ctl, alu_op} !== {5'b00011, 3'd3})
      $display("FAIL in_exec: got ctl=%b op=%0d want 00011/3", ctl, alu_op);
    else n_pass++;
  endtask

  task automatic test_halt;
    int bad;
    clear_mem(8'h00);
    mem[0] = 8'hF0;
    do_reset;
    mem_ack = 1'b1;
    next_cycle;
    next_cycle;
    n_total++;
    if ({halted, mem_rd, ctl} !== {1'b1, 1'b0, 5'b0})
      $display("FAIL halt_enter: got halted=%b rd=%b ctl=%b want 1/0/0", halted, mem_rd, ctl);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle;
      if (halted !== 1'b1 || mem_rd !== 1'b0 || ctl !== 5'b0 || pc !== 8'h01) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_wait_reset;
    int         bad;
    logic [7:0] addr0;
    clear_mem(8'h00);
    do_reset;
    mem_ack = 1'b1;
    next_cycle;
    next_cycle;
    mem_ack = 1'b0;
    next_cycle;
    addr0 = mem_addr;
    bad   = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_rd !== 1'b1 || mem_addr !== addr0 || ctl !== 5'b0 || alu_op !== 3'd0) bad++;
      next_cycle;
    end
    n_total++;
    if (addr0 !== 8'h01) $display("FAIL wait_addr: got %h want 01", addr0);
    else n_pass++;
    n_total++;
    if (bad != 0 || mem_addr !== 8'h01)
      $display("FAIL wait_hold: got %0d bad cycles addr=%h want 0/01", bad, mem_addr);
    else n_pass++;
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    next_cycle;
    n_total++;
    if ({pc, mem_addr, mem_rd, ctl, alu_op, halted} !== 26'b0)
      $display("FAIL wait_reset: got pc=%h rd=%b ctl=%b halted=%b want all 0", pc, mem_rd, ctl, halted);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'h00})
      $display("FAIL wait_refetch: got rd=%b addr=%h want 1/00", mem_rd, mem_addr);
    else n_pass++;
  endtask

  task automatic test_wrap;
    clear_mem(8'h00);
    mem[8'h00] = 8'h80;
    mem[8'h01] = 8'hFF;
    mem[8'hFF] = 8'h50;
    do_reset;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle;
    n_total++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'hFF})
      $display("FAIL wrap_fetch: got rd=%b addr=%h want 1/ff", mem_rd, mem_addr);
    else n_pass++;
    next_cycle;
    n_total++;
    if (pc !== 8'h00) $display("FAIL wrap_pc: got %h want 00", pc);
    else n_pass++;
    next_cycle;
    n_total++;
    if ({ctl, alu_op} !== {5'b00100, 3'd0})
      $display("FAIL wrap_exec: got ctl=%b op=%0d want 00100/0", ctl, alu_op);
    else n_pass++;
    next_cycle;
    n_total++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'h00})
      $display("FAIL wrap_next_fetch: got rd=%b addr=%h want 1/00", mem_rd, mem_addr);
    else n_pass++;
  endtask

  // Interpreter model: walks the program instruction by instruction, tracking the pc the
  // processor should be at and the single control pulse each instruction must produce.
  task automatic test_random;
    logic [7:0] mpc, ir, tgt, addr;
    logic [3:0] opc;
    logic [4:0] c, exp_c;
    logic [2:0] op, exp_op;
    logic       rd, h, fc;
    bit         ok, st, q;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      do_reset;
      mpc = 8'h00;
      for (int n = 0; n < 60; n++) begin
        handshake(ok, addr, st, q);
        n_total++;
        if (!ok || addr !== mpc)
          $display("FAIL rnd_fetch: got ok=%0d addr=%h want ok=1 addr=%h", ok, addr, mpc);
        else n_pass++;
        n_total++;
        if ({st, q} !== 2'b11) $display("FAIL rnd_fetch_wait: got stable=%0d quiet=%0d want 1/1", st, q);
        else n_pass++;
        if (!ok) break;
        ir  = mem[mpc];
        mpc = mpc + 8'd1;
        opc = ir[7:4];
        observe(1'b1, c, op, rd, h, fc);
        n_total++;
        if ({c, op, rd, h} !== 10'b0)
          $display("FAIL rnd_decode: got ctl=%b op=%0d rd=%b h=%b want 0", c, op, rd, h);
        else n_pass++;
        if (opc == 4'hF) begin
          observe(1'b1, c, op, rd, h, fc);
          n_total++;
          if ({h, rd, c} !== {1'b1, 1'b0, 5'b0})
            $display("FAIL rnd_halt: got h=%b rd=%b ctl=%b want 1/0/0", h, rd, c);
          else n_pass++;
          break;
        end
        if (opc == 4'h8 || opc == 4'h9) begin
          handshake(ok, addr, st, q);
          n_total++;
          if (!ok || addr !== mpc || !st || !q)
            $display("FAIL rnd_operand: got ok=%0d addr=%h want ok=1 addr=%h", ok, addr, mpc);
          else n_pass++;
          if (!ok) break;
          tgt = mem[mpc];
          mpc = mpc + 8'd1;
        end
        observe(1'b1, c, op, rd, h, fc);
        exp_op = 3'd0;
        case (opc)
          4'h1, 4'h2, 4'h3, 4'h4: begin exp_c = 5'b00001; exp_op = ir[2:0]; end
          4'h5, 4'h6:             begin exp_c = 5'b00100; exp_op = ir[2:0]; end
          4'h7:                   begin exp_c = 5'b00011; exp_op = ir[2:0]; end
          4'h8:                   begin exp_c = 5'b10000; mpc = tgt; end
          4'h9:                   begin exp_c = 5'b01000; if (fc) mpc = tgt; end
          default:                exp_c = 5'b00000;
        endcase
        n_total++;
        if ({c, op, rd, h} !== {exp_c, exp_op, 1'b0, 1'b0})
          $display("FAIL rnd_exec: ir=%h got ctl=%b op=%0d rd=%b want ctl=%b op=%0d rd=0",
                   ir, c, op, rd, exp_c, exp_op);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    flag_c  = 1'b0;
    clear_mem(8'h00);
    next_cycle;
    test_reset;
    test_sub_latency;
    test_jmp;
    test_jc(1'b0, 8'h02);
    test_jc(1'b1, 8'h20);
    test_in;
    test_halt;
    test_wait_reset;
    test_wrap;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
